// File: rtl/nes_pkg.sv
// Shared NES-side definitions: CPU I/O addresses and the sprite-DMA state encoding.
package nes_pkg;

  localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: on a CPU write to DMA_ADDR, halts the CPU and copies one 256-byte
// page from CPU memory into PPU OAM, one byte every two cycles.
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [15:0] DMA_ADDR = OAM_DMA_ADDR
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        cpu_w,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data,
  input  logic [7:0]  mem_out,
  output logic        stall,
  output logic        busy_master,
  output logic        mem_r,
  output logic        mem_w,
  output logic [15:0] mem_address,
  output logic        oam_w,
  output logic [7:0]  oam_data,
  output logic [7:0]  oam_index
);

  dma_state_t state_q, state_d;
  logic       par_q;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] buf_q, buf_d;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= IDLE;
      par_q   <= 1'b0;
      idx_q   <= '0;
      page_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      par_q   <= ~par_q;
      idx_q   <= idx_d;
      page_q  <= page_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (cpu_w && (cpu_address == DMA_ADDR)) begin
          page_d  = cpu_data;
          idx_d   = '0;
          state_d = HALT;
        end
      end
      // Landing every READ on par == 1 needs an extra dummy cycle when HALT is odd.
      HALT:  state_d = par_q ? ALIGN : READ;
      ALIGN: state_d = READ;
      READ: begin
        buf_d   = mem_out;
        state_d = WRITE;
      end
      WRITE: begin
        if (idx_q == 8'hFF) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall       = (state_q != IDLE);
    busy_master = stall;
    mem_r       = (state_q == READ);
    mem_w       = 1'b0;
    mem_address = (state_q == READ) ? {page_q, idx_q} : '0;
    oam_w       = (state_q == WRITE);
    oam_data    = (state_q == WRITE) ? buf_q : '0;
    oam_index   = (state_q == WRITE) ? idx_q : '0;
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomised scoreboard bench for oam_dma against a page-copy model of CPU memory.
module tb_oam_dma;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic        cpu_w = 1'b0;
  logic [15:0] cpu_address = '0;
  logic [7:0]  cpu_data = '0;
  logic [7:0]  mem_out;
  logic        stall, busy_master, mem_r, mem_w, oam_w;
  logic [15:0] mem_address;
  logic [7:0]  oam_data, oam_index;

  logic [7:0]  mem [0:65535];
  assign mem_out = mem[mem_address];

  oam_dma #(.DMA_ADDR(16'h4014)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .cpu_w(cpu_w), .cpu_address(cpu_address),
    .cpu_data(cpu_data), .mem_out(mem_out), .stall(stall), .busy_master(busy_master),
    .mem_r(mem_r), .mem_w(mem_w), .mem_address(mem_address), .oam_w(oam_w),
    .oam_data(oam_data), .oam_index(oam_index)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Clock edges since reset release; its parity is the DMA's notion of cycle parity.
  int unsigned edges = 0;
  always @(posedge CLK or negedge RESET_n)
    if (!RESET_n) edges <= 0;
    else          edges <= edges + 1;

  logic [15:0] exp_addr [$];
  logic [15:0] exp_oam  [$];   // {index, data}
  int unsigned exp_len  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a read, an OAM write, or ends a stall.
  int unsigned stall_cnt = 0;
  logic        prev_oam = 1'b0;
  always @(negedge CLK) begin
    if (!RESET_n) begin
      stall_cnt = 0;
      prev_oam  = 1'b0;
    end else begin
      check("busy_eq_stall", busy_master, stall);
      check("mem_w_zero", mem_w, 1'b0);
      if (mem_r) begin
        if (exp_addr.size() == 0) check("unexpected_read", 1'b1, 1'b0);
        else check("mem_address", mem_address, exp_addr.pop_front());
      end else begin
        check("mem_address_idle", mem_address, 16'h0000);
      end
      if (oam_w) begin
        check("oam_not_adjacent", prev_oam, 1'b0);
        if (exp_oam.size() == 0) check("unexpected_oam_w", 1'b1, 1'b0);
        else check("oam_index_data", {oam_index, oam_data}, exp_oam.pop_front());
      end
      if (stall) begin
        stall_cnt++;
      end else if (stall_cnt != 0) begin
        if (exp_len.size() == 0) check("unexpected_stall", stall_cnt, 0);
        else check("stall_length", stall_cnt, exp_len.pop_front());
        stall_cnt = 0;
      end
      prev_oam = oam_w;
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_w = 1'b1; cpu_address = a; cpu_data = d;
    @(negedge CLK);
    cpu_w = 1'b0; cpu_address = '0; cpu_data = '0;
  endtask

  // Trigger a transfer timed so that the HALT cycle has parity hpar.
  task automatic issue(input logic [7:0] page, input bit hpar);
    @(negedge CLK);
    if (((edges + 1) & 1) != hpar) @(negedge CLK);
    for (int i = 0; i < 256; i++) begin
      exp_addr.push_back({page, i[7:0]});
      exp_oam.push_back({i[7:0], mem[{page, i[7:0]}]});
    end
    exp_len.push_back(hpar ? 514 : 513);
    cpu_write(16'h4014, page);
    check("stall_rise", stall, 1'b1);
  endtask

  task automatic wait_oam(input logic [7:0] idx);
    int cyc = 0;
    while (!(oam_w && oam_index == idx) && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
    end
    check("wait_oam_timeout", (cyc < 2000), 1'b1);
  endtask

  task automatic wait_done();
    int cyc = 0;
    while ((stall || exp_oam.size() != 0 || exp_len.size() != 0) && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
    end
    check("done_timeout", (cyc < 2000), 1'b1);
    check("queues_empty", exp_oam.size() + exp_addr.size() + exp_len.size(), 0);
  endtask

  task automatic check_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("quiet_stall", stall, 1'b0);
      check("quiet_mem_r", mem_r, 1'b0);
      check("quiet_oam_w", oam_w, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_mem_r", mem_r, 1'b0);
    check("rst_mem_w", mem_w, 1'b0);
    check("rst_mem_address", mem_address, 16'h0000);
    check("rst_oam_w", oam_w, 1'b0);
    check("rst_oam_data", oam_data, 8'h00);
    check("rst_oam_index", oam_index, 8'h00);
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;

    // Writes to other addresses must not start anything.
    @(negedge CLK);
    cpu_write(16'h4015, 8'h02);
    cpu_write(16'h2004, 8'h02);
    check_quiet(4);

    issue(8'h02, 1'b0); wait_done();
    issue(8'h02, 1'b1); wait_done();
    issue(8'h07, 1'($urandom)); wait_done();

    // Retrigger mid-transfer is ignored.
    issue(8'h02, 1'b0);
    wait_oam(8'd50);
    cpu_write(16'h4014, 8'h03);
    wait_done();

    // Trigger sampled on the edge leaving the last WRITE is ignored.
    issue(8'h02, 1'($urandom));
    wait_oam(8'd255);
    cpu_write(16'h4014, 8'h05);
    check("end_trigger_ignored", stall, 1'b0);
    check_quiet(3);
    wait_done();

    // Reset mid-transfer aborts at once.
    issue(8'h02, 1'b0);
    wait_oam(8'd100);
    #2 RESET_n = 1'b0;
    #1;
    check("abort_stall", stall, 1'b0);
    check("abort_oam_w", oam_w, 1'b0);
    check("abort_mem_r", mem_r, 1'b0);
    check("abort_busy", busy_master, 1'b0);
    exp_addr.delete(); exp_oam.delete(); exp_len.delete();
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
    check_quiet(2);
    issue(8'h02, 1'b0); wait_done();

    for (int t = 0; t < 4; t++) begin
      repeat ($urandom_range(0, 5)) @(negedge CLK);
      issue(8'($urandom), 1'($urandom));
      wait_done();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
